// File: rtl/osc_sequencer.sv
// DFF-chain oscillator sequencer: ring / Johnson stepping with period counting.
// Optional OSC_SEQ_HOLD_EN adds a hold input that freezes a run in place.
module osc_sequencer #(
    parameter int STAGES = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              mode,
    input  logic [STAGES-1:0] seed,
    input  logic [CNT_W-1:0]  periods,
`ifdef OSC_SEQ_HOLD_EN
    input  logic              hold,
`endif
    output logic [STAGES-1:0] phase,
    output logic              tick,
    output logic              busy,
    output logic              done
);

    localparam int SW = $clog2(2 * STAGES);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state, state_d;
    logic [STAGES-1:0] phase_d;
    logic              tick_d, busy_d, done_d;
    logic [SW-1:0]     step, step_d;
    logic [CNT_W-1:0]  pcnt, pcnt_d;
    logic [CNT_W-1:0]  per_q, per_d;
    logic              mode_q, mode_d;

    logic              adv;
    logic [SW-1:0]     last;
    logic              wrap;
    logic [STAGES-1:0] shifted;
    logic [CNT_W-1:0]  pcnt_inc;

`ifdef OSC_SEQ_HOLD_EN
    assign adv = ~hold;
`else
    assign adv = 1'b1;
`endif

    // Johnson inverts the feedback bit, doubling the period length
    assign last     = mode_q ? SW'(2 * STAGES - 1) : SW'(STAGES - 1);
    assign wrap     = (step == last);
    assign shifted  = {phase[STAGES-2:0], phase[STAGES-1] ^ mode_q};
    assign pcnt_inc = pcnt + CNT_W'(1);

    always_comb begin
        state_d = state;
        phase_d = phase;
        tick_d  = 1'b0;
        busy_d  = busy;
        done_d  = 1'b0;
        step_d  = step;
        pcnt_d  = pcnt;
        mode_d  = mode_q;
        per_d   = per_q;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    mode_d  = mode;
                    per_d   = periods;
                    step_d  = '0;
                    pcnt_d  = '0;
                    if (mode)
                        phase_d = '0;
                    else if (seed == '0)
                        phase_d = STAGES'(1);
                    else
                        phase_d = seed;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (adv) begin
                    phase_d = shifted;
                    if (wrap) begin
                        step_d = '0;
                        tick_d = 1'b1;
                        pcnt_d = pcnt_inc;
                        if (per_q != '0 && pcnt_inc == per_q) begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        step_d = step + SW'(1);
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            phase  <= '0;
            tick   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            step   <= '0;
            pcnt   <= '0;
            per_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            state  <= state_d;
            phase  <= phase_d;
            tick   <= tick_d;
            busy   <= busy_d;
            done   <= done_d;
            step   <= step_d;
            pcnt   <= pcnt_d;
            per_q  <= per_d;
            mode_q <= mode_d;
        end
    end

endmodule

// File: tb/tb_osc_sequencer.sv
// Directed bench for osc_sequencer with a per-cycle expected-output queue.
// Hold scenario is built only when OSC_SEQ_HOLD_EN is defined.
module tb_osc_sequencer;

    typedef struct packed {
        logic [3:0] phase;
        logic       tick;
        logic       busy;
        logic       done;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset, start, stop, mode, hold;
    logic [3:0] seed;
    logic [7:0] periods;
    logic [3:0] phase;
    logic       tick, busy, done;

    int   checks = 0;
    int   errors = 0;
    obs_t sb_q[$];

    always #5 clk = ~clk;

    osc_sequencer #(.STAGES(4), .CNT_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .seed    (seed),
        .periods (periods),
`ifdef OSC_SEQ_HOLD_EN
        .hold    (hold),
`endif
        .phase   (phase),
        .tick    (tick),
        .busy    (busy),
        .done    (done)
    );

    // Drive one cycle, queue the expected post-edge outputs, then compare.
    task automatic cyc(input string tag, input logic rs, input logic st,
                       input logic sp, input logic [3:0] ph, input logic tk,
                       input logic bz, input logic dn);
        obs_t e, o;
        reset = rs;
        start = st;
        stop  = sp;
        sb_q.push_back({ph, tk, bz, dn});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        o = {phase, tick, busy, done};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed ph=%b t=%b b=%b d=%b expected ph=%b t=%b b=%b d=%b",
                   tag, o.phase, o.tick, o.busy, o.done,
                   e.phase, e.tick, e.busy, e.done);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0;
        mode = 1'b0; seed = 4'b0001; periods = 8'd2;
        #2;
        cyc("reset", 1, 0, 0, 4'b0000, 0, 0, 0);
        cyc("idle0", 0, 0, 0, 4'b0000, 0, 0, 0);

        // Ring, seed 0001, two periods
        cyc("r_load", 0, 1, 0, 4'b0001, 0, 1, 0);
        cyc("r_s1",   0, 0, 0, 4'b0010, 0, 1, 0);
        cyc("r_s2",   0, 0, 0, 4'b0100, 0, 1, 0);
        cyc("r_s3",   0, 0, 0, 4'b1000, 0, 1, 0);
        cyc("r_s4",   0, 0, 0, 4'b0001, 1, 1, 0);
        cyc("r_s5",   0, 0, 0, 4'b0010, 0, 1, 0);
        cyc("r_s6",   0, 0, 0, 4'b0100, 0, 1, 0);
        cyc("r_s7",   0, 0, 0, 4'b1000, 0, 1, 0);
        cyc("r_done", 0, 0, 0, 4'b0001, 1, 0, 1);
        cyc("r_idle", 0, 0, 0, 4'b0001, 0, 0, 0);
        cyc("r_hold", 0, 0, 0, 4'b0001, 0, 0, 0);

        // Johnson, one period; seed ignored, start re-pulsed in RUN and DONE
        mode = 1'b1; seed = 4'b1010; periods = 8'd1;
        cyc("j_load", 0, 1, 0, 4'b0000, 0, 1, 0);
        cyc("j_s1",   0, 0, 0, 4'b0001, 0, 1, 0);
        cyc("j_s2",   0, 1, 0, 4'b0011, 0, 1, 0);
        cyc("j_s3",   0, 0, 0, 4'b0111, 0, 1, 0);
        cyc("j_s4",   0, 0, 0, 4'b1111, 0, 1, 0);
        cyc("j_s5",   0, 0, 0, 4'b1110, 0, 1, 0);
        cyc("j_s6",   0, 0, 0, 4'b1100, 0, 1, 0);
        cyc("j_s7",   0, 0, 0, 4'b1000, 0, 1, 0);
        cyc("j_done", 0, 0, 0, 4'b0000, 1, 0, 1);
        cyc("j_dnst", 0, 1, 0, 4'b0000, 0, 0, 0);
        mode = 1'b0; seed = 4'b0100;
        cyc("j_idle", 0, 0, 0, 4'b0000, 0, 0, 0);

        // Ring, seed 0 loads one-hot, free-run, stop after five shifts
        seed = 4'b0000; periods = 8'd0;
        cyc("f_load", 0, 1, 0, 4'b0001, 0, 1, 0);
        cyc("f_s1",   0, 0, 0, 4'b0010, 0, 1, 0);
        cyc("f_s2",   0, 0, 0, 4'b0100, 0, 1, 0);
        cyc("f_s3",   0, 0, 0, 4'b1000, 0, 1, 0);
        cyc("f_s4",   0, 0, 0, 4'b0001, 1, 1, 0);
        cyc("f_s5",   0, 0, 0, 4'b0010, 0, 1, 0);
        cyc("f_stop", 0, 0, 1, 4'b0010, 0, 0, 0);
        cyc("f_stst", 0, 1, 1, 4'b0010, 0, 0, 0);
        cyc("f_idle", 0, 0, 0, 4'b0010, 0, 0, 0);

        // Stop wins over a simultaneous wrap
        seed = 4'b1000; periods = 8'd1;
        cyc("w_load", 0, 1, 0, 4'b1000, 0, 1, 0);
        cyc("w_s1",   0, 0, 0, 4'b0001, 0, 1, 0);
        cyc("w_s2",   0, 0, 0, 4'b0010, 0, 1, 0);
        cyc("w_s3",   0, 0, 0, 4'b0100, 0, 1, 0);
        cyc("w_stop", 0, 0, 1, 4'b0100, 0, 0, 0);
        cyc("w_idle", 0, 0, 0, 4'b0100, 0, 0, 0);

        // Reset mid-run in Johnson, then a normal run
        mode = 1'b1; periods = 8'd0;
        cyc("x_load", 0, 1, 0, 4'b0000, 0, 1, 0);
        cyc("x_s1",   0, 0, 0, 4'b0001, 0, 1, 0);
        cyc("x_s2",   0, 0, 0, 4'b0011, 0, 1, 0);
        cyc("x_s3",   0, 0, 0, 4'b0111, 0, 1, 0);
        cyc("x_rst",  1, 0, 0, 4'b0000, 0, 0, 0);
        cyc("x_idle", 0, 0, 0, 4'b0000, 0, 0, 0);
        mode = 1'b0; seed = 4'b0011; periods = 8'd1;
        cyc("y_load", 0, 1, 0, 4'b0011, 0, 1, 0);
        cyc("y_s1",   0, 0, 0, 4'b0110, 0, 1, 0);
        cyc("y_s2",   0, 0, 0, 4'b1100, 0, 1, 0);
        cyc("y_s3",   0, 0, 0, 4'b1001, 0, 1, 0);
        cyc("y_done", 0, 0, 0, 4'b0011, 1, 0, 1);
        cyc("y_idle", 0, 0, 0, 4'b0011, 0, 0, 0);

`ifdef OSC_SEQ_HOLD_EN
        // Hold three cycles at 0100 delays the tick by three cycles
        seed = 4'b0001; periods = 8'd1;
        cyc("h_load", 0, 1, 0, 4'b0001, 0, 1, 0);
        cyc("h_s1",   0, 0, 0, 4'b0010, 0, 1, 0);
        cyc("h_s2",   0, 0, 0, 4'b0100, 0, 1, 0);
        hold = 1'b1;
        cyc("h_h1",   0, 0, 0, 4'b0100, 0, 1, 0);
        cyc("h_h2",   0, 0, 0, 4'b0100, 0, 1, 0);
        cyc("h_h3",   0, 0, 0, 4'b0100, 0, 1, 0);
        hold = 1'b0;
        cyc("h_s3",   0, 0, 0, 4'b1000, 0, 1, 0);
        cyc("h_done", 0, 0, 0, 4'b0001, 1, 0, 1);
        cyc("h_idle", 0, 0, 0, 4'b0001, 0, 0, 0);
`endif

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_empty: observed %0d entries expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
